// File: rtl/uart_arb_pkg.sv
`default_nettype none
// uart_arb_pkg: shared FSM encoding and default byte width for uart_tx_arbiter. Rev 1.0
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    CLEAR = 2'd3
  } arb_state_t;

  localparam int DEFAULT_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap. Rev 1.0
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic             hit;
  logic [IDX_W-1:0] k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    hit       = 1'b0;
    k         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!hit && req[k]) begin
        hit       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = k;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// uart_tx_arbiter: round-robin byte arbiter in front of a UART TX start/busy/clear handshake.
// Optional per-byte watchdog enabled by UART_ARB_TIMEOUT_EN. Rev 1.0
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEFAULT_DATA_W
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_busy,
  input  logic                       tx_clear_req,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   gidx;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0]  sel_data;
  logic               busy_meta, busy_s;
  logic               clr_meta, clr_s;
  logic               accept;
  logic               tmo_hit;

  // The transmitter runs on an unrelated clock; only the synchronized copies reach the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
      clr_meta  <= 1'b0;
      clr_s     <= 1'b0;
    end else begin
      busy_meta <= tx_busy;
      busy_s    <= busy_meta;
      clr_meta  <= tx_clear_req;
      clr_s     <= clr_meta;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx == IDX_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign active    = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  assign tmo_hit = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo_hit;
      if (accept || tmo_hit) cnt <= '0;
      else if (state != IDLE) cnt <= cnt + 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
    end else if (tmo_hit) begin
      state    <= IDLE;
      tx_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data  <= sel_data;
            grant_id <= gidx;
            ptr      <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          // Held until the slow side has visibly taken the byte.
          if (busy_s) begin
            tx_start <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (clr_s) state <= CLEAR;
        end
        CLEAR: begin
          if (!clr_s && !busy_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
